// File: rtl/soc_bus_decoder.sv
// Single-outstanding address decoder: routes one upstream request to one of NbSlaves windows, errors unmapped/timed-out accesses.
// Latency: 1 cycle unmapped, >=2 cycles mapped; req_ready_o only in IDLE, response held until resp_ready_i.
module soc_bus_decoder #(
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned NbSlaves      = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [63:0]              req_addr_i,
    input  logic                     req_we_i,
    input  logic [63:0]              req_wdata_i,
    input  logic [7:0]               req_be_i,

    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [63:0]              resp_rdata_o,
    output logic                     resp_err_o,

    output logic [NbSlaves-1:0]      slv_req_o,
    output logic [63:0]              slv_addr_o,
    output logic                     slv_we_o,
    output logic [63:0]              slv_wdata_o,
    output logic [7:0]               slv_be_o,
    input  logic [NbSlaves-1:0]      slv_gnt_i,
    input  logic [NbSlaves-1:0]      slv_rvalid_i,
    input  logic [NbSlaves*64-1:0]   slv_rdata_i,
    input  logic [NbSlaves-1:0]      slv_err_i
);

    localparam int unsigned CntW   = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
    localparam int unsigned NbWin  = 5;

    // Window table, index order DRAM, ZYNQ, CLINT, PLIC, Debug (ROM sits inside ZYNQ).
    localparam logic [NbWin-1:0][63:0] WinBase = {
        64'h0000_0000_0000_0000,
        64'h0000_0000_0C00_0000,
        64'h0000_0000_0200_0000,
        64'h0000_0000_E000_0000,
        64'h0000_0000_8000_0000
    };
    localparam logic [NbWin-1:0][63:0] WinLen = {
        64'h0000_0000_0000_1000,
        64'h0000_0000_03FF_FFFF,
        64'h0000_0000_000C_0000,
        64'h0000_0000_2000_0000,
        64'h0000_0000_2000_0000
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  be;
    } req_t;

    state_e                state_q;
    req_t                  req_q;
    logic [CntW-1:0]       cnt_q;
    logic [NbSlaves-1:0]   tgt_q;
    logic [NbSlaves-1:0]   slv_req_q;
    logic [63:0]           resp_rdata_q;
    logic                  resp_err_q;

    logic [NbWin-1:0]      win_hit;
    logic [NbSlaves-1:0]   dec_sel;
    logic                  busy;
    logic                  timeout;
    logic                  tgt_gnt;
    logic                  tgt_rvalid;
    logic [63:0]           tgt_rdata;
    logic                  tgt_err;

    // Offset compare after the base check keeps the upper bound free of wrap-around.
    always_comb begin
        win_hit = '0;
        for (int k = 0; k < NbWin; k++) begin
            if ((req_addr_i >= WinBase[k]) && ((req_addr_i - WinBase[k]) < WinLen[k])) begin
                win_hit[k] = 1'b1;
            end
        end
        dec_sel = NbSlaves'(win_hit);
    end

    always_comb begin
        tgt_gnt    = |(slv_gnt_i & tgt_q);
        tgt_rvalid = |(slv_rvalid_i & tgt_q);
        tgt_rdata  = '0;
        tgt_err    = 1'b0;
        for (int k = 0; k < NbSlaves; k++) begin
            if (tgt_q[k]) begin
                tgt_rdata = slv_rdata_i[64*k +: 64];
                tgt_err   = slv_err_i[k];
            end
        end
    end

    assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign timeout = busy && (cnt_q == CntMax);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            tgt_q        <= '0;
            slv_req_q    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (busy && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_q <= '{addr: req_addr_i, we: req_we_i, wdata: req_wdata_i, be: req_be_i};
                        cnt_q <= '0;
                        tgt_q <= dec_sel;
                        if (|dec_sel) begin
                            slv_req_q <= dec_sel;
                            state_q   <= ST_REQ;
                        end else begin
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    if (timeout) begin
                        slv_req_q    <= '0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (tgt_gnt) begin
                        slv_req_q <= '0;
                        if (tgt_rvalid) begin
                            resp_rdata_q <= tgt_rdata;
                            resp_err_q   <= tgt_err;
                            state_q      <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (timeout) begin
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (tgt_rvalid) begin
                        resp_rdata_q <= tgt_rdata;
                        resp_err_q   <= tgt_err;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Request drops in the very cycle the counter hits its limit, so a slave sees at most TimeoutCycles request cycles.
    assign slv_req_o    = slv_req_q & {NbSlaves{~timeout}};
    assign req_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign slv_addr_o   = req_q.addr;
    assign slv_we_o     = req_q.we;
    assign slv_wdata_o  = req_q.wdata;
    assign slv_be_o     = req_q.be;

endmodule

// File: doc/soc_bus_decoder.md
SOC_BUS_DECODER -- requirements
Module: soc_bus_decoder

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, giving the maximum cycles from slave request to slave response before an error response.
REQ-002 SHALL have parameter NbSlaves, default 5, giving the number of slave ports, indexed DRAM=0, ZYNQ=1, CLINT=2, PLIC=3, Debug=4.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have upstream request ports: req_valid_i in 1, req_ready_o out 1, req_addr_i in 64, req_we_i in 1, req_wdata_i in 64, req_be_i in 8.
REQ-006 SHALL have upstream response ports: resp_valid_o out 1, resp_ready_i in 1, resp_rdata_o out 64, resp_err_o out 1.
REQ-007 SHALL have downstream ports: slv_req_o out NbSlaves (one-hot), slv_addr_o out 64, slv_we_o out 1, slv_wdata_o out 64, slv_be_o out 8, slv_gnt_i in NbSlaves, slv_rvalid_i in NbSlaves, slv_rdata_i in NbSlaves*64 (slave k at bits [64k+63:64k]), slv_err_i in NbSlaves.

Function
REQ-008 SHALL decode an address into slave k iff Base_k <= addr < Base_k+Length_k, with no wrap past 2^64.
REQ-009 SHALL use these windows: DRAM 0x8000_0000 + 0x2000_0000; ZYNQ 0xE000_0000 + 0x2000_0000; CLINT 0x0200_0000 + 0xC_0000; PLIC 0x0C00_0000 + 0x3FF_FFFF; Debug 0x0000_0000 + 0x1000.
REQ-010 SHALL route the ROM window at 0xFC00_0000 to ZYNQ, because that window lies inside the ZYNQ window.
REQ-011 SHALL treat any address matching no window as unmapped.
REQ-012 SHALL implement the states IDLE, REQ, WAIT, RESP.
REQ-013 SHALL drive req_ready_o=1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-014 SHALL register addr/we/wdata/be on accept; slv_addr_o, slv_we_o, slv_wdata_o and slv_be_o SHALL present those registered values.
REQ-015 On accept of a mapped address, SHALL go IDLE->REQ and assert bit k of slv_req_o from the next cycle.
REQ-016 On accept of an unmapped address, SHALL go IDLE->RESP with resp_err_o=1 and resp_rdata_o=0; no slv_req_o bit SHALL assert.
REQ-017 In REQ, SHALL hold slv_req_o[k] until slv_gnt_i[k]=1 is sampled, then deassert it the following cycle.
REQ-018 In REQ, on grant SHALL go to WAIT; if slv_rvalid_i[k] is also 1 in the grant cycle, SHALL go directly to RESP.
REQ-019 In WAIT, on slv_rvalid_i[k]=1 SHALL capture slave k's rdata and err, then go to RESP.
REQ-020 SHALL ignore slv_gnt_i and slv_rvalid_i bits of non-target slaves, and all such bits while in IDLE or RESP.
REQ-021 SHALL clear a timeout counter on accept and increment it each cycle in REQ or WAIT.
REQ-022 When the counter reaches TimeoutCycles, SHALL drop slv_req_o, go to RESP with resp_err_o=1 and resp_rdata_o=0; this SHALL take priority over a same-cycle grant or rvalid.
REQ-023 The counter SHALL be wide enough to hold TimeoutCycles and SHALL saturate, never wrap.
REQ-024 In RESP, SHALL assert resp_valid_o with stable rdata/err until resp_ready_i=1, then return to IDLE.
REQ-025 SHALL NOT assert req_ready_o in the cycle resp completes; the next request is accepted no earlier than the cycle after return to IDLE.
REQ-026 Minimum mapped latency, accept to resp_valid_o: 2 cycles when grant and rvalid coincide in the first REQ cycle.
REQ-027 Unmapped latency SHALL be 1 cycle.
REQ-028 SHALL keep at most one transaction outstanding.

Reset
REQ-029 On rst_i=1 at a clock edge, SHALL enter IDLE and clear the counter and captured data.
REQ-030 Under reset, outputs SHALL be: req_ready_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, slv_req_o=0, slv_addr_o=0, slv_we_o=0, slv_wdata_o=0, slv_be_o=0.
REQ-031 Reset mid-transaction SHALL abandon it with no response, drop slv_req_o the next cycle, and ignore late slave responses.
REQ-032 SHALL drive req_ready_o=1 in the first cycle after rst_i deasserts.

Verification
REQ-033 Read 0x8000_0010, gnt+rvalid in first REQ cycle, rdata=0xDEAD_BEEF -> slv_req_o=5'b00001 for 1 cycle; resp_valid_o 2 cycles after accept with rdata 0xDEAD_BEEF, err=0.
REQ-034 Access 0x4000_0000 (unmapped) -> no slv_req_o; resp_valid_o next cycle, err=1, rdata=0.
REQ-035 Boundaries: 0x0200_0000 -> CLINT; 0x020B_FFFF -> CLINT; 0x020C_0000 -> err; 0x0FFF_FFFE -> PLIC; 0x0FFF_FFFF -> err; 0xFC00_0000 -> ZYNQ (5'b00010); 0xFFFF_FFFF -> ZYNQ.
REQ-036 TimeoutCycles=8, Debug slave never grants -> slv_req_o[4] held, then dropped after 8 cycles; err=1, rdata=0; a later rvalid from Debug while IDLE is ignored.
REQ-037 resp_ready_i held low 10 cycles after response -> resp_valid_o and data stable; req_ready_o=0 throughout; IDLE after the handshake.
REQ-038 rst_i pulsed in WAIT -> slv_req_o=0 and resp_valid_o=0 next cycle; req_ready_o=1 the cycle after rst_i deasserts.
